// File: rtl/synfull_deliver_collector.sv
// Delivered-packet collector: FWFT FIFO of {id,size,src} toward the traffic
// model, with receive/drop statistics and an end-of-injection drain tracker.
module synfull_deliver_collector #(
   parameter int DEPTH    = 16,
   parameter int EAw      = 8,
   parameter int PCK_SIZw = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pck_wr_i,
   input  logic [31:0]              pck_data_i,
   input  logic [PCK_SIZw-1:0]      pck_size_i,
   input  logic [EAw-1:0]           pck_src_i,
   input  logic                     end_i,
   output logic                     del_valid_o,
   input  logic                     del_ready_i,
   output logic [31:0]              del_id_o,
   output logic [PCK_SIZw-1:0]      del_size_o,
   output logic [EAw-1:0]           del_src_o,
   output logic [$clog2(DEPTH):0]   occupancy_o,
   output logic                     overflow_o,
   output logic [63:0]              rsv_pck_cnt_o,
   output logic [63:0]              rsv_flit_cnt_o,
   output logic [31:0]              drop_cnt_o,
   output logic                     done_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

   logic [31:0]         id_mem   [DEPTH];
   logic [PCK_SIZw-1:0] size_mem [DEPTH];
   logic [EAw-1:0]      src_mem  [DEPTH];

   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q;
   logic [63:0]   pck_q, flit_q;
   logic [31:0]   drop_q;
   state_e        state_q, state_d;

   logic pop, full, wr_acc, drop;

   assign full   = (cnt_q == FULL);
   assign pop    = del_valid_o & del_ready_i;
   // A pop on a full FIFO frees the slot the incoming write lands in.
   assign wr_acc = pck_wr_i & (~full | pop);
   assign drop   = pck_wr_i & full & ~pop;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_acc && !pop)
         cnt_d = cnt_q + ONE;
      else if (!wr_acc && pop)
         cnt_d = cnt_q - ONE;
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         id_mem[wr_q]   <= pck_data_i;
         size_mem[wr_q] <= pck_size_i;
         src_mem[wr_q]  <= pck_src_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         pck_q  <= '0;
         flit_q <= '0;
         drop_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (wr_acc)
            wr_q <= wr_q + 1'b1;
         if (pop)
            rd_q <= rd_q + 1'b1;
         if (pck_wr_i) begin
            pck_q  <= pck_q + 64'd1;
            flit_q <= flit_q + 64'(pck_size_i);
         end
         if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != '1)
               drop_q <= drop_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (end_i) state_d = DRAIN;
         DRAIN:   if (cnt_d == '0 && !wr_acc) state_d = DONE;
         DONE:    if (wr_acc) state_d = DRAIN;
         default: state_d = RUN;
      endcase
   end

   // Head fields read as zero while the FIFO is empty.
   assign del_valid_o    = (cnt_q != '0);
   assign del_id_o       = del_valid_o ? id_mem[rd_q]   : '0;
   assign del_size_o     = del_valid_o ? size_mem[rd_q] : '0;
   assign del_src_o      = del_valid_o ? src_mem[rd_q]  : '0;
   assign occupancy_o    = cnt_q;
   assign overflow_o     = ovf_q;
   assign rsv_pck_cnt_o  = pck_q;
   assign rsv_flit_cnt_o = flit_q;
   assign drop_cnt_o     = drop_q;
   assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_synfull_deliver_collector.sv
// Randomized bench for synfull_deliver_collector against a queue-based
// reference model, plus directed delivery/overflow/drain/reset scenarios.
module tb_synfull_deliver_collector;

   localparam int DEPTH = 16;
   localparam int EAw   = 8;
   localparam int PSW   = 10;

   logic            clk = 1'b0;
   logic            reset;
   logic            pck_wr_i;
   logic [31:0]     pck_data_i;
   logic [PSW-1:0]  pck_size_i;
   logic [EAw-1:0]  pck_src_i;
   logic            end_i;
   logic            del_valid_o;
   logic            del_ready_i;
   logic [31:0]     del_id_o;
   logic [PSW-1:0]  del_size_o;
   logic [EAw-1:0]  del_src_o;
   logic [4:0]      occupancy_o;
   logic            overflow_o;
   logic [63:0]     rsv_pck_cnt_o;
   logic [63:0]     rsv_flit_cnt_o;
   logic [31:0]     drop_cnt_o;
   logic            done_o;

   synfull_deliver_collector #(
      .DEPTH(DEPTH), .EAw(EAw), .PCK_SIZw(PSW)
   ) dut (
      .clk(clk), .reset(reset),
      .pck_wr_i(pck_wr_i), .pck_data_i(pck_data_i),
      .pck_size_i(pck_size_i), .pck_src_i(pck_src_i),
      .end_i(end_i),
      .del_valid_o(del_valid_o), .del_ready_i(del_ready_i),
      .del_id_o(del_id_o), .del_size_o(del_size_o),
      .del_src_o(del_src_o),
      .occupancy_o(occupancy_o), .overflow_o(overflow_o),
      .rsv_pck_cnt_o(rsv_pck_cnt_o),
      .rsv_flit_cnt_o(rsv_flit_cnt_o),
      .drop_cnt_o(drop_cnt_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: drain phase as 0=running, 1=draining, 2=finished.
   logic [31:0]    m_id[$];
   logic [PSW-1:0] m_sz[$];
   logic [EAw-1:0] m_src[$];
   logic [63:0]    m_pck, m_flit;
   logic [31:0]    m_drop;
   logic           m_ovf;
   int             m_phase;
   int             next_id = 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_id.delete(); m_sz.delete(); m_src.delete();
      m_pck = '0; m_flit = '0; m_drop = '0;
      m_ovf = 1'b0; m_phase = 0;
   endtask

   task automatic model_step(input logic r, input logic w,
                             input logic [31:0] id,
                             input logic [PSW-1:0] sz,
                             input logic [EAw-1:0] src,
                             input logic e, input logic rd);
      bit p, acc;
      if (r) begin
         model_clear();
         return;
      end
      p   = (m_id.size() > 0) && rd;
      acc = w && (m_id.size() < DEPTH || p);
      if (w) begin
         m_pck  = m_pck + 64'd1;
         m_flit = m_flit + 64'(sz);
      end
      if (w && !acc) begin
         m_ovf = 1'b1;
         if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
      end
      if (p) begin
         void'(m_id.pop_front());
         void'(m_sz.pop_front());
         void'(m_src.pop_front());
      end
      if (acc) begin
         m_id.push_back(id); m_sz.push_back(sz); m_src.push_back(src);
      end
      case (m_phase)
         0: if (e) m_phase = 1;
         1: if (m_id.size() == 0 && !acc) m_phase = 2;
         default: if (acc) m_phase = 1;
      endcase
   endtask

   task automatic compare_all();
      int n;
      n = m_id.size();
      chk("occupancy", 64'(occupancy_o), 64'(n));
      chk("valid", 64'(del_valid_o), 64'(n != 0));
      chk("del_id", 64'(del_id_o), n ? 64'(m_id[0]) : 64'd0);
      chk("del_size", 64'(del_size_o), n ? 64'(m_sz[0]) : 64'd0);
      chk("del_src", 64'(del_src_o), n ? 64'(m_src[0]) : 64'd0);
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      chk("rsv_pck", rsv_pck_cnt_o, m_pck);
      chk("rsv_flit", rsv_flit_cnt_o, m_flit);
      chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
      chk("done", 64'(done_o), 64'(m_phase == 2));
   endtask

   task automatic step(input logic r, input logic w,
                       input logic [31:0] id,
                       input logic [PSW-1:0] sz,
                       input logic [EAw-1:0] src,
                       input logic e, input logic rd);
      reset = r; pck_wr_i = w; pck_data_i = id;
      pck_size_i = sz; pck_src_i = src; end_i = e; del_ready_i = rd;
      model_step(r, w, id, sz, src, e, rd);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic wr_pkt(input logic rd);
      step(1'b0, 1'b1, 32'(next_id), PSW'($urandom_range(1, 20)),
           EAw'($urandom), 1'b0, rd);
      next_id++;
   endtask

   task automatic idle(input logic rd);
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, rd);
   endtask

   initial begin
      model_clear();
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);

      // single delivery
      step(1'b0, 1'b1, 32'hA5, PSW'(4), EAw'(3), 1'b0, 1'b1);
      chk("single_valid", 64'(del_valid_o), 64'd1);
      chk("single_id", 64'(del_id_o), 64'hA5);
      idle(1'b1);
      chk("single_popped", 64'(del_valid_o), 64'd0);
      chk("single_pck", rsv_pck_cnt_o, 64'd1);
      chk("single_flit", rsv_flit_cnt_o, 64'd4);

      // overflow on 17 writes with consumer stalled
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      next_id = 100;
      for (int i = 0; i < 17; i++) wr_pkt(1'b0);
      chk("ovf_occ", 64'(occupancy_o), 64'd16);
      chk("ovf_flag", 64'(overflow_o), 64'd1);
      chk("ovf_drop", 64'(drop_cnt_o), 64'd1);
      chk("ovf_pck", rsv_pck_cnt_o, 64'd17);
      for (int i = 0; i < 16; i++) begin
         chk("ovf_order", 64'(del_id_o), 64'(100 + i));
         idle(1'b1);
      end

      // full FIFO, write and pop together
      for (int i = 0; i < 16; i++) wr_pkt(1'b0);
      wr_pkt(1'b1);
      chk("full_wp_occ", 64'(occupancy_o), 64'd16);
      chk("full_wp_drop", 64'(drop_cnt_o), 64'd1);
      for (int i = 0; i < 16; i++) idle(1'b1);

      // drain tracking with late packet
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) wr_pkt(1'b0);
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("drain_not_done", 64'(done_o), 64'd0);
      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("drain_done", 64'(done_o), 64'd1);
      wr_pkt(1'b0);
      chk("late_not_done", 64'(done_o), 64'd0);
      idle(1'b1);
      chk("late_done", 64'(done_o), 64'd1);

      // end_i on empty FIFO: done two cycles later
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("empty_end_1", 64'(done_o), 64'd0);
      idle(1'b0);
      chk("empty_end_2", 64'(done_o), 64'd1);

      // reset mid-operation with entries and overflow set
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) wr_pkt(1'b0);
      for (int i = 0; i < 11; i++) idle(1'b1);
      chk("pre_rst_occ", 64'(occupancy_o), 64'd5);
      step(1'b1, 1'b1, 32'h77, PSW'(9), EAw'(1), 1'b1, 1'b1);
      chk("rst_occ", 64'(occupancy_o), 64'd0);
      chk("rst_ovf", 64'(overflow_o), 64'd0);
      chk("rst_pck", rsv_pck_cnt_o, 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic r, w, e, rd;
         r  = ($urandom_range(0, 299) == 0);
         w  = ($urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 35));
         e  = ($urandom_range(0, 59) == 0);
         rd = ($urandom_range(0, 99) < ((i / 300) % 2 ? 25 : 75));
         step(r, w, $urandom, PSW'($urandom), EAw'($urandom), e, rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
